spi_readout_tx: RTL and testbench
=================================

Name: spi_readout_tx

Overview:
- SPI read-side transmitter for the chip's register map.
- Decodes the read command from MOSI and drives global or channel register select lines into the register-file mux.
- Serialises the returned byte MSB-first on MISO.
- Burst mode: while cs stays active, the address auto-increments and consecutive bytes stream out, with incremental channel/register tracking.

Parameters:
- N_GLOBAL, 11, number of global registers at addresses 0..N_GLOBAL-1
- N_CH, 8, number of channels
- REGS_PER_CH, 7, readable registers per channel; channel block occupies N_GLOBAL..N_GLOBAL+N_CH*REGS_PER_CH-1 (11..66)
- FILL_BYTE, 8'h00, byte returned for unmapped addresses

Ports:
- sclk  in  1  SPI clock, the only clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cs  in  1  transaction active (high = selected); cs low asynchronously clears FSM (internal clear = rst | !cs)
- mosi  in  1  command stream, sampled on rising sclk
- miso  out  1  read data; changes on rising sclk, master samples on falling
- miso_oe  out  1  high while driving read data
- rd_active  out  1  high in TURN/DATA states
- glob_sel  out  4  global register index 0..10; 4'hF when none
- ch_sel  out  3  channel index 0..N_CH-1; 3'b111 when none
- reg_sel  out  3  per-channel register 0..REGS_PER_CH-1; 3'b111 when none
- addr_cur  out  7  current read address
- rd_data  in  8  byte from register-file mux; combinational from sel outputs; sampled one sclk after sel change

Behaviour:
- Reset/clear values: miso=0, miso_oe=0, rd_active=0, glob_sel=4'hF, ch_sel=3'b111, reg_sel=3'b111, addr_cur=0, FSM=IDLE, bit counter=0.
- Command byte: 8 bits MSB-first; bit7 = R/W (1 = read), bits6:0 = address.
- FSM states:
  - IDLE: on the first edge with cs high, shift mosi into the command register and go to CMD.
  - CMD: shift 7 more bits (edges 1..7). On edge 7 (8th bit), latch addr_cur and decode selects. If bit7=1, go to TURN; else go to IGNORE.
  - TURN: one edge. Load shift register with rd_data, or FILL_BYTE if unmapped. miso = bit7, miso_oe=1. Go to DATA with bit counter=7.
  - DATA: each edge shifts the next bit out (6..0).
    - On the edge presenting bit0, advance addr_cur by 1 (7-bit wrap 127->0) and update selects.
    - Next edge loads the new rd_data and presents its bit7; no gap between bytes.
  - IGNORE: write commands are handled elsewhere. miso=0, miso_oe=0 until cs drops.
- Decode at latch: addr<N_GLOBAL gives glob_sel=addr, ch/reg=111. Addr in channel range gives ch_sel=(addr-N_GLOBAL)/REGS_PER_CH and reg_sel=(addr-N_GLOBAL)%REGS_PER_CH (constant-compare chain allowed). Otherwise all selects are invalid.
- Burst increment is incremental, with no divider:
  - Global 10 -> ch0 reg0.
  - reg_sel==REGS_PER_CH-1 -> reg_sel=0, ch_sel+1.
  - Last channel register (66) -> invalid.
  - 127 -> 0 gives glob_sel=0.
- Latency: first data bit on MISO at rising edge 9 (after 8 cmd edges + 1 turnaround edge).
- cs low mid-byte: immediate asynchronous clear to reset values; a partial byte is discarded; the next transaction starts cleanly.
- rst mid-transaction: same as cs low. A transaction resumes only on a fresh cs-high sequence after rst deasserts.
- rst and cs transitions simultaneous: rst dominates; the outputs are identical in either case.

Optional Feature:
- PARITY_EN:
  - Defined: each output byte is followed by one odd-parity bit (9-bit frames).
  - Address advance and the next load shift one edge later: advance on the parity edge, next bit7 on the edge after.
  - Undefined: plain 8-bit frames as above.

Test Plan:
- Read addr 5, rd_data=0x3C for glob_sel=5 -> glob_sel=5, ch/reg=111; MISO bits 0,0,1,1,1,1,0,0 on edges 9..16.
- Read addr 25, mux returns 0xA5 for ch2/reg0 -> ch_sel=2, reg_sel=0; MISO 1,0,1,0,0,1,0,1.
- Burst read from addr 17 for 3 bytes -> selects (ch0,reg6), (ch1,reg0), (ch1,reg1); addr_cur 17,18,19; no idle bit between bytes.
- Read addr 66 then burst, and read addr 70 -> first byte from ch7/reg6; following bytes FILL_BYTE 0x00 with all selects invalid.
- Write command 0x0B -> IGNORE; miso=0, miso_oe=0 for the whole transaction; selects stay invalid.
- cs dropped after edge 11 of a read, then new read of addr 12 -> outputs at reset values immediately; new transaction returns ch0/reg1 data correctly. Repeat with rst pulse instead of cs drop: same result.

Source files
------------

// File: rtl/spi_readout_tx.sv
// spi_readout_tx: SPI read transmitter that decodes a read command, drives register selects and streams bytes MSB-first with burst auto-increment.
// Optional odd-parity bit after each byte when PARITY_EN is defined.
module spi_readout_tx #(
  parameter int N_GLOBAL = 11,
  parameter int N_CH = 8,
  parameter int REGS_PER_CH = 7,
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       rd_active,
  output logic [3:0] glob_sel,
  output logic [2:0] ch_sel,
  output logic [2:0] reg_sel,
  output logic [6:0] addr_cur,
  input  logic [7:0] rd_data
);
`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam logic [3:0] FRAME = PAR ? 4'd8 : 4'd7;
  typedef enum logic [2:0] {IDLE, CMD, TURN, DATA, IGNORE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, glob_q, glob_d, dg, ng;
  logic [6:0] cmd_q, cmd_d, addr_q, addr_d, a;
  logic [7:0] sh_q, sh_d, ld;
  logic [2:0] ch_q, ch_d, rg_q, rg_d, dc, dr, nc, nr;
  logic par_q, par_d, miso_q, miso_d, oe_q, oe_d, clr, load;
  assign clr = rst | ~cs;
  assign a = {cmd_q[5:0], mosi};
  assign ld = (glob_q != 4'hF || rg_q != 3'h7) ? rd_data : FILL_BYTE;
  assign load = state_q == TURN || (state_q == DATA && cnt_q == 4'd0);
  always_comb begin
    dg = 4'hF;
    dc = 3'h7;
    dr = 3'h7;
    if (a < 7'(N_GLOBAL)) dg = a[3:0];
    else
      for (int c = 0; c < N_CH; c++)
        if (a >= 7'(N_GLOBAL + c * REGS_PER_CH) && a < 7'(N_GLOBAL + (c + 1) * REGS_PER_CH)) begin
          dc = 3'(c);
          dr = 3'(a - 7'(N_GLOBAL + c * REGS_PER_CH));
        end
  end
  // Burst advance walks the map incrementally instead of re-dividing the address
  always_comb begin
    ng = 4'hF;
    nc = 3'h7;
    nr = 3'h7;
    if (glob_q != 4'hF) begin
      if (glob_q == 4'(N_GLOBAL - 1)) begin
        nc = 3'd0;
        nr = 3'd0;
      end else ng = glob_q + 4'd1;
    end else if (rg_q != 3'h7) begin
      if (rg_q != 3'(REGS_PER_CH - 1)) begin
        nc = ch_q;
        nr = rg_q + 3'd1;
      end else if (ch_q != 3'(N_CH - 1)) begin
        nc = ch_q + 3'd1;
        nr = 3'd0;
      end
    end else if (addr_q == 7'h7F) ng = 4'd0;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cmd_d = cmd_q;
    sh_d = sh_q;
    par_d = par_q;
    miso_d = miso_q;
    oe_d = oe_q;
    addr_d = addr_q;
    glob_d = glob_q;
    ch_d = ch_q;
    rg_d = rg_q;
    if (state_q == IDLE) begin
      cmd_d = {6'd0, mosi};
      cnt_d = 4'd1;
      state_d = CMD;
    end else if (state_q == CMD) begin
      cmd_d = a;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd7) begin
        addr_d = a;
        cnt_d = 4'd0;
        state_d = cmd_q[6] ? TURN : IGNORE;
        glob_d = cmd_q[6] ? dg : glob_q;
        ch_d = cmd_q[6] ? dc : ch_q;
        rg_d = cmd_q[6] ? dr : rg_q;
      end
    end else if (load) begin
      sh_d = ld;
      miso_d = ld[7];
      par_d = ~^ld;
      oe_d = 1'b1;
      cnt_d = FRAME;
      state_d = DATA;
    end else if (state_q == DATA) begin
      sh_d = sh_q << 1;
      miso_d = (PAR && cnt_q == 4'd1) ? par_q : sh_q[6];
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        addr_d = addr_q + 7'd1;
        glob_d = ng;
        ch_d = nc;
        rg_d = nr;
      end
    end
  end
  always_ff @(posedge sclk or posedge clr)
    if (clr) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      cmd_q <= 7'd0;
      sh_q <= 8'd0;
      par_q <= 1'b0;
      miso_q <= 1'b0;
      oe_q <= 1'b0;
      addr_q <= 7'd0;
      glob_q <= 4'hF;
      ch_q <= 3'h7;
      rg_q <= 3'h7;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cmd_q <= cmd_d;
      sh_q <= sh_d;
      par_q <= par_d;
      miso_q <= miso_d;
      oe_q <= oe_d;
      addr_q <= addr_d;
      glob_q <= glob_d;
      ch_q <= ch_d;
      rg_q <= rg_d;
    end
  assign miso = miso_q;
  assign miso_oe = oe_q;
  assign rd_active = state_q == TURN || state_q == DATA;
  assign glob_sel = glob_q;
  assign ch_sel = ch_q;
  assign reg_sel = rg_q;
  assign addr_cur = addr_q;
endmodule

// File: tb/tb_spi_readout_tx.sv
// tb_spi_readout_tx: directed self-checking bench for spi_readout_tx with a small register-file mux model.
module tb_spi_readout_tx;
  logic sclk, rst, cs, mosi, miso, miso_oe, rd_active;
  logic [3:0] glob_sel;
  logic [2:0] ch_sel, reg_sel;
  logic [6:0] addr_cur;
  logic [7:0] rd_data;
  int checks = 0, errors = 0;
  spi_readout_tx dut (
    .sclk(sclk), .rst(rst), .cs(cs), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .rd_active(rd_active), .glob_sel(glob_sel), .ch_sel(ch_sel), .reg_sel(reg_sel),
    .addr_cur(addr_cur), .rd_data(rd_data)
  );
  // Register file: unmapped selects return 0xEE so the fill byte is distinguishable
  always_comb
    rd_data = glob_sel != 4'hF ? (glob_sel == 4'd5 ? 8'h3C : {4'h4, glob_sel}) :
              reg_sel != 3'h7 ? ((ch_sel == 3'd2 && reg_sel == 3'd0) ? 8'hA5 : {1'b0, ch_sel, 1'b1, reg_sel}) : 8'hEE;
  initial begin
    sclk = 0;
    forever #5 sclk = ~sclk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk(tag, {12'd0, miso, miso_oe, rd_active, glob_sel, ch_sel, reg_sel, addr_cur}, {15'd0, 4'hF, 3'h7, 3'h7, 7'd0});
  endtask
  task automatic chk_sel(input string tag, input logic [3:0] g, input logic [2:0] c, input logic [2:0] r, input logic [6:0] a);
    chk(tag, {15'd0, glob_sel, ch_sel, reg_sel, addr_cur}, {15'd0, g, c, r, a});
  endtask
  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) begin
      @(negedge sclk);
      cs = 1;
      mosi = c[i];
      @(posedge sclk);
      #1;
    end
    @(negedge sclk);
    mosi = 0;
  endtask
  task automatic rd_byte(input string tag, input logic [7:0] exp);
    for (int i = 7; i >= 0; i--) begin
      @(posedge sclk);
      #1;
      chk(tag, {30'd0, miso_oe, miso}, {30'd0, 1'b1, exp[i]});
    end
`ifdef PARITY_EN
    @(posedge sclk);
    #1;
    chk({tag, "_par"}, {31'd0, miso}, {31'd0, ~^exp});
`endif
  endtask
  task automatic end_tx(input string tag);
    @(negedge sclk);
    cs = 0;
    #1;
    chk_reset(tag);
  endtask
  initial begin
    rst = 1;
    cs = 0;
    mosi = 0;
    #22;
    chk_reset("reset");
    rst = 0;
    send_cmd(8'h85);
    chk_sel("sel_a5", 4'd5, 3'h7, 3'h7, 7'd5);
    chk("rd_active_a5", {31'd0, rd_active}, 32'd1);
    rd_byte("data_a5", 8'h3C);
    end_tx("end_a5");
    send_cmd(8'h99);
    chk_sel("sel_a25", 4'hF, 3'd2, 3'd0, 7'd25);
    rd_byte("data_a25", 8'hA5);
    end_tx("end_a25");
    send_cmd(8'h91);
    chk_sel("sel_b17", 4'hF, 3'd0, 3'd6, 7'd17);
    rd_byte("data_b17", 8'h0E);
    chk_sel("sel_b18", 4'hF, 3'd1, 3'd0, 7'd18);
    rd_byte("data_b18", 8'h18);
    chk_sel("sel_b19", 4'hF, 3'd1, 3'd1, 7'd19);
    rd_byte("data_b19", 8'h19);
    end_tx("end_b17");
    send_cmd(8'hC2);
    chk_sel("sel_a66", 4'hF, 3'd7, 3'd6, 7'd66);
    rd_byte("data_a66", 8'h7E);
    chk_sel("sel_a67", 4'hF, 3'h7, 3'h7, 7'd67);
    rd_byte("data_a67", 8'h00);
    chk_sel("sel_a68", 4'hF, 3'h7, 3'h7, 7'd68);
    rd_byte("data_a68", 8'h00);
    end_tx("end_a66");
    send_cmd(8'hC6);
    chk_sel("sel_a70", 4'hF, 3'h7, 3'h7, 7'd70);
    rd_byte("data_a70", 8'h00);
    end_tx("end_a70");
    send_cmd(8'h8A);
    chk_sel("sel_a10", 4'd10, 3'h7, 3'h7, 7'd10);
    rd_byte("data_a10", 8'h4A);
    chk_sel("sel_a11", 4'hF, 3'd0, 3'd0, 7'd11);
    rd_byte("data_a11", 8'h08);
    end_tx("end_a10");
    send_cmd(8'hFF);
    chk_sel("sel_a127", 4'hF, 3'h7, 3'h7, 7'd127);
    rd_byte("data_a127", 8'h00);
    chk_sel("sel_wrap", 4'd0, 3'h7, 3'h7, 7'd0);
    rd_byte("data_wrap", 8'h40);
    end_tx("end_a127");
    send_cmd(8'h0B);
    for (int i = 0; i < 10; i++) begin
      @(posedge sclk);
      #1;
      chk("write_ignore", {19'd0, miso_oe, miso, rd_active, glob_sel, ch_sel, reg_sel}, {22'd0, 4'hF, 3'h7, 3'h7});
    end
    end_tx("end_write");
    send_cmd(8'h8C);
    repeat (3) @(posedge sclk);
    #2;
    cs = 0;
    #1;
    chk_reset("cs_drop");
    send_cmd(8'h8C);
    chk_sel("sel_a12", 4'hF, 3'd0, 3'd1, 7'd12);
    rd_byte("data_a12", 8'h09);
    end_tx("end_a12");
    send_cmd(8'h8C);
    repeat (3) @(posedge sclk);
    #2;
    rst = 1;
    #1;
    chk_reset("rst_pulse");
    cs = 0;
    #3;
    rst = 0;
    send_cmd(8'h8C);
    chk_sel("sel_a12_rst", 4'hF, 3'd0, 3'd1, 7'd12);
    rd_byte("data_a12_rst", 8'h09);
    end_tx("end_a12_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
